sobel_stream_filter: RTL
========================

Name: sobel_stream_filter

Overview:
- Parametrised streaming 3x3 Sobel stage for the edge-detect pipeline. Sits between the grayscale FIFO and the output FIFO.
- Consumes raster-order grayscale pixels and emits exactly one result per input pixel.
- Generalises the fixed Sobel stage with run-time output mode, a threshold, frame-size parameters, explicit border handling, backpressure-safe output and frame-done status.

Parameters:
- WIDTH, 720, pixels per line (>=3)
- HEIGHT, 540, lines per frame (>=3)
- PIXEL_WIDTH, 8, bits per grayscale pixel

Ports:
- clock  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-low.
- in_dout  in  PIXEL_WIDTH  pixel at head of input FIFO.
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pop input FIFO.
- out_din  out  PIXEL_WIDTH  result to output FIFO.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  push output FIFO.
- mode  in  2  0=|gx|+|gy| saturated, 1=binary threshold, 2=|gx| saturated, 3=|gy| saturated.
- threshold  in  PIXEL_WIDTH+3  compare value for mode 1.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse on the write of the final output of a frame.

Behaviour:
- Reset: while reset==0 at a clock edge, the following are cleared: in_rd_en, out_wr_en, busy, frame_done, out_valid, out_din=0, all counters, line buffers, window and state=S_FILL. A mid-frame reset discards the partial frame; the next pixel read is treated as pixel (0,0).
- Window: two WIDTH-deep line buffers plus a 3x3 register window. The newest window tap is in_dout at consume time.
- Centre: consuming input index p (raster, p=r*WIDTH+c) produces the result for centre index p-WIDTH-1.
- Output register: out_valid/out_din. out_wr_en = out_valid & ~out_full. The register advances when ~out_valid | ~out_full.
- States:
  - S_FILL: in_rd_en = ~in_empty. No results. Leave to S_RUN after WIDTH+1 pixels consumed. mode and threshold are latched on the consume of pixel 0. busy is set on that consume.
  - S_RUN: in_rd_en = ~in_empty & (~out_valid | ~out_full). Each consume loads one result into the output register on the next edge, so latency is 1 cycle from consume to out_din valid. Leave to S_DRAIN after pixel WIDTH*HEIGHT-1 is consumed.
  - S_DRAIN: in_rd_en=0. Emit the remaining WIDTH+1 results as padded-zero-neighbour border outputs, one per advance. After the last write: frame_done=1 for one cycle, busy=0, counters cleared, return to S_FILL.
- Arithmetic:
  - gx = (p[-1][+1] + 2p[0][+1] + p[+1][+1]) - (same for the -1 column). gy is the analogous row difference.
  - Both are signed PIXEL_WIDTH+3 bits. Magnitudes are unsigned PIXEL_WIDTH+3 bits.
  - Saturating modes clamp to 2^PIXEL_WIDTH-1.
  - Mode 1 outputs all-ones when (|gx|+|gy|) >= threshold, else 0.
- Borders: a centre on row 0, row HEIGHT-1, column 0 or column WIDTH-1 outputs 0 in every mode. Column counters guarantee no left/right wrap between lines.
- Simultaneous events:
  - out_full high with out_valid: hold out_din, stall input.
  - in_empty in S_RUN: no consume; a pending result is still written when ~out_full.
  - frame end and next frame's pixel 0 available: first consume of the next frame occurs the cycle after frame_done.
- mode/threshold changes mid-frame have no effect until the next frame.

Decomposition:
- Package sobel_pkg holds:
  - state enum {S_FILL, S_RUN, S_DRAIN}
  - mode encodings
  - kernel weight constants
  - width function for PIXEL_WIDTH+3
- Sub-module line_buffer: WIDTH-deep, PIXEL_WIDTH-wide shift delay with enable. Instantiated twice.

Test Plan (WIDTH=4, HEIGHT=4, PIXEL_WIDTH=8):
- Flat frame, all 100, mode 0 -> 16 writes, all 0. frame_done on the 16th write only. busy low afterwards.
- Rows {0,0,255,255}, mode 0 -> interior (1,1),(1,2),(2,1),(2,2)=255, borders 0. Mode 3 -> all 0. Mode 2 -> interior 255.
- Rows {0,10,20,30}, mode 1: interior gx=80, gy=0. threshold=80 -> interior 255. threshold=81 -> interior 0.
- Same ramp with out_full forced high for 10 cycles after the 6th pixel -> in_rd_en stays 0 while out_valid; out_din held; output sequence identical to the no-stall run.
- Reset low one edge after 7 pixels, then a full flat-100 frame -> exactly 16 writes, all 0, no residue from the aborted frame.
- Two back-to-back frames, mode changed from 0 to 1 mid-frame one -> frame one entirely mode 0, frame two mode 1. Continuous input gives one write per cycle in S_RUN.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel stage.
package sobel_pkg;

   typedef enum logic [1:0] {
      S_FILL,
      S_RUN,
      S_DRAIN
   } state_e;

   typedef enum logic [1:0] {
      M_SUM = 2'd0,
      M_THR = 2'd1,
      M_GX  = 2'd2,
      M_GY  = 2'd3
   } mode_e;

   localparam int KW_SIDE = 1;
   localparam int KW_MID  = 2;

   // Signed gradient width: 4 * max pixel plus sign.
   function automatic int grad_width(input int pw);
      return pw + 3;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line pixel delay: dout is the pixel pushed DEPTH enables earlier.
module line_buffer #(
   parameter int DEPTH = 720,
   parameter int PW    = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          en,
   input  logic [PW-1:0] din,
   output logic [PW-1:0] dout
);

   logic [PW-1:0] mem_q [DEPTH];
   logic [PW-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (en) begin
         mem_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) mem_q <= '{default: '0};
      else        mem_q <= mem_d;
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel stage: raster pixels in, one result out per pixel,
// border centres forced to zero, output register tolerant of backpressure.
module sobel_stream_filter
   import sobel_pkg::*;
#(
   parameter int WIDTH       = 720,
   parameter int HEIGHT      = 540,
   parameter int PIXEL_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [PIXEL_WIDTH-1:0] in_dout,
   input  logic                   in_empty,
   output logic                   in_rd_en,
   output logic [PIXEL_WIDTH-1:0] out_din,
   input  logic                   out_full,
   output logic                   out_wr_en,
   input  logic [1:0]             mode,
   input  logic [PIXEL_WIDTH+2:0] threshold,
   output logic                   busy,
   output logic                   frame_done
);

   localparam int GW = grad_width(PIXEL_WIDTH);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam int DW = $clog2(WIDTH + 2);

   typedef logic [PIXEL_WIDTH-1:0] pix_t;
   typedef logic signed [GW-1:0]   grad_t;
   typedef logic [GW-1:0]          mag_t;

   localparam grad_t K_SIDE  = grad_t'(KW_SIDE);
   localparam grad_t K_MID   = grad_t'(KW_MID);
   localparam mag_t  PIX_MAX = mag_t'((1 << PIXEL_WIDTH) - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [DW-1:0] drn_q, drn_d;
   mode_e         mode_q, mode_d;
   mag_t          thr_q, thr_d;
   logic          busy_q, busy_d;
   logic          out_valid_q, out_valid_d;
   pix_t          out_din_q, out_din_d;
   logic          last_q, last_d;
   pix_t          wl_q [3];
   pix_t          wl_d [3];
   pix_t          wm_q [3];
   pix_t          wm_d [3];
   pix_t          tap1, tap2, res;
   logic          adv, col_end, row_end, border, load, drn_load;
   grad_t         gx, gy;
   mag_t          ax, ay, sum;

   function automatic grad_t ext(input pix_t v);
      return grad_t'(v);
   endfunction

   function automatic pix_t sat(input mag_t v);
      return (v > PIX_MAX) ? '1 : v[PIXEL_WIDTH-1:0];
   endfunction

   line_buffer #(.DEPTH(WIDTH), .PW(PIXEL_WIDTH)) u_lb1 (
      .clock(clock), .reset(reset), .en(in_rd_en),
      .din(in_dout), .dout(tap1)
   );

   line_buffer #(.DEPTH(WIDTH), .PW(PIXEL_WIDTH)) u_lb2 (
      .clock(clock), .reset(reset), .en(in_rd_en),
      .din(tap1), .dout(tap2)
   );

   always_ff @(posedge clock) begin
      if (!reset) state_q <= S_FILL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FILL:  if (in_rd_en && col_q == '0 && row_q == RW'(1)) state_d = S_RUN;
         S_RUN:   if (in_rd_en && col_end && row_end) state_d = S_DRAIN;
         S_DRAIN: if (frame_done) state_d = S_FILL;
         default: state_d = S_FILL;
      endcase
   end

   always_comb begin
      adv        = ~out_valid_q | ~out_full;
      out_wr_en  = reset & out_valid_q & ~out_full;
      frame_done = out_wr_en & last_q;
      in_rd_en   = 1'b0;
      unique case (state_q)
         S_FILL:  in_rd_en = reset & ~in_empty;
         S_RUN:   in_rd_en = reset & ~in_empty & adv;
         default: in_rd_en = 1'b0;
      endcase
   end

   // Right column is the live taps; wl/wm hold the two older columns.
   always_comb begin
      gx = K_SIDE * (ext(tap2) + ext(in_dout)) + K_MID * ext(tap1)
         - K_SIDE * (ext(wl_q[0]) + ext(wl_q[2])) - K_MID * ext(wl_q[1]);
      gy = K_SIDE * (ext(wl_q[2]) + ext(in_dout)) + K_MID * ext(wm_q[2])
         - K_SIDE * (ext(wl_q[0]) + ext(tap2)) - K_MID * ext(wm_q[0]);
      ax  = gx[GW-1] ? mag_t'(-gx) : mag_t'(gx);
      ay  = gy[GW-1] ? mag_t'(-gy) : mag_t'(gy);
      sum = ax + ay;
      res = '0;
      unique case (mode_q)
         M_SUM:   res = sat(sum);
         M_THR:   res = (sum >= thr_q) ? '1 : '0;
         M_GX:    res = sat(ax);
         M_GY:    res = sat(ay);
         default: res = '0;
      endcase
   end

   always_comb begin
      col_end  = col_q == CW'(WIDTH - 1);
      row_end  = row_q == RW'(HEIGHT - 1);
      border   = col_q <= CW'(1) || row_q == RW'(1);
      drn_load = state_q == S_DRAIN && adv && drn_q != DW'(WIDTH + 1);
      load     = (state_q == S_RUN && in_rd_en) || drn_load;
      col_d       = col_q;
      row_d       = row_q;
      drn_d       = drn_q;
      mode_d      = mode_q;
      thr_d       = thr_q;
      busy_d      = busy_q;
      wl_d        = wl_q;
      wm_d        = wm_q;
      out_valid_d = out_valid_q;
      out_din_d   = out_din_q;
      last_d      = last_q;
      if (in_rd_en) begin
         col_d = col_end ? '0 : col_q + 1'b1;
         if (col_end) row_d = row_end ? '0 : row_q + 1'b1;
         wl_d = wm_q;
         wm_d = '{tap2, tap1, in_dout};
         if (state_q == S_FILL && col_q == '0 && row_q == '0) begin
            mode_d = mode_e'(mode);
            thr_d  = threshold;
            busy_d = 1'b1;
         end
      end
      if (drn_load) drn_d = drn_q + 1'b1;
      if (adv) begin
         out_valid_d = load;
         last_d      = drn_load && drn_q == DW'(WIDTH);
         if (load) out_din_d = (state_q == S_RUN && !border) ? res : '0;
      end
      if (frame_done) begin
         busy_d = 1'b0;
         drn_d  = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         col_q       <= '0;
         row_q       <= '0;
         drn_q       <= '0;
         mode_q      <= M_SUM;
         thr_q       <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_din_q   <= '0;
         last_q      <= 1'b0;
         wl_q        <= '{default: '0};
         wm_q        <= '{default: '0};
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         drn_q       <= drn_d;
         mode_q      <= mode_d;
         thr_q       <= thr_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_din_q   <= out_din_d;
         last_q      <= last_d;
         wl_q        <= wl_d;
         wm_q        <= wm_d;
      end
   end

   assign out_din = out_din_q;
   assign busy    = busy_q;

endmodule
